fifo_sync_param: RTL
====================

Name: fifo_sync_param

Overview:
Parametrised synchronous FIFO. It is the next-generation replacement for the fixed 8x16 FIFO used across the FPGA codebase. It adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty flags, a selectable read mode (show-ahead or registered), synchronous flush, and sticky overflow/underflow error flags. It sits between a single-clock producer and consumer, for example between UART RX and a command parser.

Parameters:
DW, 8, data width in bits (>=1)
AW, 4, address width; DEPTH = 2**AW entries (AW>=2)
AF_TH, 14, almost_full asserts when count >= AF_TH (1..DEPTH)
AE_TH, 2, almost_empty asserts when count <= AE_TH (0..DEPTH-1)
FWFT, 1, 1 = show-ahead (dout = head word combinationally); 0 = registered read data, 1-cycle latency

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
wr  in  1  write request
din  in  DW  write data
rd  in  1  read request
dout  out  DW  read data
flush  in  1  synchronous clear of contents
clr_err  in  1  synchronous clear of the sticky error flags
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_TH
almost_empty  out  1  count <= AE_TH
count  out  AW+1  current occupancy, 0..DEPTH
dout_valid  out  1  dout holds a valid word this cycle
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Storage: DEPTH x DW register array, written on clk. No reset on the array.
- Pointers: wp and rp are AW bits wide and wrap naturally from DEPTH-1 to 0. count is an AW+1-bit register.
- Accept rules, evaluated on registered state at the clock edge:
  - wr_acc = wr & ~full
  - rd_acc = rd & ~empty
- wr_acc: mem[wp] <= din; wp <= wp+1.
- rd_acc: rp <= rp+1.
- count update: count <= count + wr_acc - rd_acc.
- Simultaneous rd and wr:
  - When full: read accepted, write dropped; overflow is set; count goes to DEPTH-1.
  - When empty: write accepted, read dropped; underflow is set; count goes to 1.
  - Otherwise both are accepted and count is unchanged.
- Flags full, empty, almost_full and almost_empty are combinational decodes of the registered count. They therefore reflect each edge immediately and lag no request.
- FWFT=1:
  - dout = mem[rp], combinational.
  - dout_valid = ~empty.
  - The first word written appears on dout the cycle after its write edge.
- FWFT=0:
  - On rd_acc, dout <= mem[rp] at the same edge; dout_valid <= 1 for exactly that following cycle.
  - With no rd_acc, dout holds its value and dout_valid <= 0.
- Sticky error flags:
  - overflow <= 1 on (wr & full); underflow <= 1 on (rd & empty).
  - clr_err clears both flags. If clr_err and a new error occur in the same cycle, the set wins.
- flush has priority over wr and rd:
  - wp, rp and count go to 0; dout_valid goes to 0; dout holds its value.
  - Array contents are not cleared.
  - Error flags are unaffected.
- Reset, asynchronous active-low, applies immediately mid-operation:
  - wp = rp = 0, count = 0.
  - empty = 1, full = 0.
  - almost_empty = 1; almost_full = 0 unless AF_TH == 0, which is illegal.
  - overflow = underflow = 0, dout_valid = 0.
  - dout = 0 when FWFT=0; when FWFT=1, dout shows mem[0], which is undefined.
- Latency:
  - Write to empty deasserting: 1 edge.
  - Write to data visible on dout: 1 cycle for FWFT=1, 2 cycles for FWFT=0.

Decomposition:
- Shared package fifo_pkg holds:
  - the clog2 helper;
  - the read-mode constants FIFO_FWFT=1 and FIFO_REG=0;
  - an elaboration-time parameter check that AF_TH and AE_TH are in range.
- One natural sub-module, fifo_ptr_ctrl, contains pointers, count, flag decode and error flags.
- Storage and the read-mode mux stay in the top module.

Test Plan:
1. Reset, FWFT=1: hold rst=0, then release -> empty=1, almost_empty=1, full=0, count=0, overflow=underflow=0. Write 0x11 -> next cycle dout=0x11, dout_valid=1, count=1.
2. Fill: write 0x00..0x0F (16 words) -> almost_full rises when count reaches 14; full=1 at count=16. A 17th write of 0xAA sets overflow, count stays 16, and the next 16 reads return exactly 0x00..0x0F.
3. Wrap-around: cycle 40 writes and reads at 50% occupancy -> data order preserved across the pointer wrap at 15 to 0, and count never exceeds 16.
4. Simultaneous events:
   - rd and wr at full -> count becomes 15, overflow=1.
   - rd and wr at empty with din=0x5A -> count=1, underflow=1, dout=0x5A next cycle.
   - rd and wr at count=8 -> count stays 8.
5. FWFT=0: write 0x3C, then pulse rd -> dout=0x3C with dout_valid=1 for exactly one cycle, one edge after the rd edge. Read while empty -> underflow=1, dout_valid=0.
6. flush and reset mid-operation:
   - At count=9, flush together with wr -> count=0, empty=1, the write is dropped.
   - clr_err clears the sticky flags.
   - Async rst asserted between clock edges -> all outputs take their reset values immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and elaboration helpers for the parametrised FIFO
package fifo_pkg;
  localparam int FIFO_FWFT = 1;
  localparam int FIFO_REG = 0;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic bit th_ok(input int aw, input int af, input int ae);
    return af >= 1 && af <= (1 << aw) && ae >= 0 && ae < (1 << aw);
  endfunction
endpackage

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: pointers, occupancy count, level flags and sticky error flags
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int AW = 4,
  parameter int AF_TH = 14,
  parameter int AE_TH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_i,
  input  logic          rd_i,
  input  logic          flush_i,
  input  logic          clr_err_i,
  output logic [AW-1:0] wp_o,
  output logic [AW-1:0] rp_o,
  output logic          wr_acc_o,
  output logic          rd_acc_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          almost_full_o,
  output logic          almost_empty_o,
  output logic          overflow_o,
  output logic          underflow_o
);
  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);
  localparam logic [AW:0] AF = (AW+1)'(AF_TH);
  localparam logic [AW:0] AE = (AW+1)'(AE_TH);
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  assign full_o = cnt_q == DEPTH;
  assign empty_o = cnt_q == '0;
  assign almost_full_o = cnt_q >= AF;
  assign almost_empty_o = cnt_q <= AE;
  // flush outranks both requests, so acceptance is gated here once
  assign wr_acc_o = wr_i & ~full_o & ~flush_i;
  assign rd_acc_o = rd_i & ~empty_o & ~flush_i;
  always_comb begin
    wp_d = flush_i ? '0 : wp_q + AW'(wr_acc_o);
    rp_d = flush_i ? '0 : rp_q + AW'(rd_acc_o);
    cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(wr_acc_o) - (AW+1)'(rd_acc_o);
    ovf_d = (wr_i & full_o) | (ovf_q & ~clr_err_i);
    unf_d = (rd_i & empty_o) | (unf_q & ~clr_err_i);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  assign wp_o = wp_q;
  assign rp_o = rp_q;
  assign count_o = cnt_q;
  assign overflow_o = ovf_q;
  assign underflow_o = unf_q;
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with level flags, sticky errors and
// selectable show-ahead or registered read data
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int AF_TH = 14,
  parameter int AE_TH = 2,
  parameter int FWFT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  input  logic          flush,
  input  logic          clr_err,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          dout_valid,
  output logic          overflow,
  output logic          underflow
);
  localparam int DEPTH = 1 << AW;
  if (!th_ok(AW, AF_TH, AE_TH)) begin : g_bad_th
    $error("fifo_sync_param: AF_TH/AE_TH out of range");
  end
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr_acc, rd_acc;
  logic [DW-1:0] dout_q, dout_d;
  logic dv_q;
  fifo_ptr_ctrl #(.AW(AW), .AF_TH(AF_TH), .AE_TH(AE_TH)) u_ctrl (
    .clk(clk), .rst(rst), .wr_i(wr), .rd_i(rd), .flush_i(flush), .clr_err_i(clr_err),
    .wp_o(wp), .rp_o(rp), .wr_acc_o(wr_acc), .rd_acc_o(rd_acc), .count_o(count),
    .full_o(full), .empty_o(empty), .almost_full_o(almost_full),
    .almost_empty_o(almost_empty), .overflow_o(overflow), .underflow_o(underflow)
  );
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wp] <= din;
  end
  // registered path is pruned by synthesis when show-ahead is selected
  assign dout_d = rd_acc ? mem[rp] : dout_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
      dv_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      dv_q <= rd_acc;
    end
  end
  assign dout = (FWFT == FIFO_FWFT) ? mem[rp] : dout_q;
  assign dout_valid = (FWFT == FIFO_FWFT) ? ~empty : dv_q;
endmodule
